// File: rtl/delay_sweep_ctrl_if.sv
// rtl/delay_sweep_ctrl_if.sv - host-side control, config and status bundle for the delay sweep scheduler
interface delay_sweep_ctrl_if #(
  parameter int DW = 16,
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic [DW-1:0] del_start;
  logic [DW-1:0] del_step;
  logic [CW-1:0] n_points;
  logic [CW-1:0] n_shots;
  logic [DW-1:0] del_out;
  logic          del_valid;
  logic [CW-1:0] point_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic          sat;

  modport master (
    output start, abort, del_start, del_step, n_points, n_shots,
    input  del_out, del_valid, point_idx, busy, done, cfg_err, sat
  );

  modport slave (
    input  start, abort, del_start, del_step, n_points, n_shots,
    output del_out, del_valid, point_idx, busy, done, cfg_err, sat
  );
endinterface

// File: rtl/delay_sweep_ctrl.sv
// rtl/delay_sweep_ctrl.sv - steps the pulse delay through a programmed sweep, holding each point for n_shots sync periods
module delay_sweep_ctrl #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  delay_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [DW-1:0] del_out_q, del_out_d;
  logic          del_valid_q, del_valid_d;
  logic [CW-1:0] point_idx_q, point_idx_d;
  logic [CW-1:0] shot_cnt_q, shot_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          sat_q, sat_d;
  logic [DW-1:0] step_q, step_d;
  logic [CW-1:0] npts_q, npts_d;
  logic [CW-1:0] nshots_q, nshots_d;

  logic          sync_rise;
  logic [DW:0]   del_sum;

  assign sync_d    = {sync_q[1:0], sync_in};
  assign sync_rise = sync_q[1] & ~sync_q[2];
  // One extra bit so a carry out of the delay word can be detected and clamped.
  assign del_sum   = {1'b0, del_out_q} + {1'b0, step_q};

  always_comb begin
    state_d     = state_q;
    del_out_d   = del_out_q;
    del_valid_d = 1'b0;
    point_idx_d = point_idx_q;
    shot_cnt_d  = shot_cnt_q;
    done_d      = done_q;
    cfg_err_d   = cfg_err_q;
    sat_d       = sat_q;
    step_d      = step_q;
    npts_d      = npts_q;
    nshots_d    = nshots_q;

    if (bus.abort) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      shot_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            done_d = 1'b0;
            if (bus.n_points == '0 || bus.n_shots == '0) begin
              cfg_err_d = 1'b1;
            end else begin
              step_d      = bus.del_step;
              npts_d      = bus.n_points;
              nshots_d    = bus.n_shots;
              del_out_d   = bus.del_start;
              del_valid_d = 1'b1;
              point_idx_d = '0;
              shot_cnt_d  = '0;
              sat_d       = 1'b0;
              cfg_err_d   = 1'b0;
              state_d     = S_ARM;
            end
          end
        end
        // The first period after a delay change may predate it, so it is not counted.
        S_ARM: begin
          if (sync_rise) state_d = S_RUN;
        end
        S_RUN: begin
          if (sync_rise) begin
            if (shot_cnt_q != nshots_q - CW'(1)) begin
              shot_cnt_d = shot_cnt_q + CW'(1);
            end else if (point_idx_q == npts_q - CW'(1)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              point_idx_d = point_idx_q + CW'(1);
              shot_cnt_d  = '0;
              del_valid_d = 1'b1;
              del_out_d   = del_sum[DW] ? '1 : del_sum[DW-1:0];
              if (del_sum[DW]) sat_d = 1'b1;
              state_d     = S_ARM;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_ARM) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      del_out_q   <= '0;
      del_valid_q <= 1'b0;
      point_idx_q <= '0;
      shot_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      sat_q       <= 1'b0;
      step_q      <= '0;
      npts_q      <= '0;
      nshots_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      del_out_q   <= del_out_d;
      del_valid_q <= del_valid_d;
      point_idx_q <= point_idx_d;
      shot_cnt_q  <= shot_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      sat_q       <= sat_d;
      step_q      <= step_d;
      npts_q      <= npts_d;
      nshots_q    <= nshots_d;
    end
  end

  assign bus.del_out   = del_out_q;
  assign bus.del_valid = del_valid_q;
  assign bus.point_idx = point_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// tb/tb_delay_sweep_ctrl.sv - directed bench for delay_sweep_ctrl against an edge-counting sweep model
module tb_delay_sweep_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sync_in = 1'b0;

  delay_sweep_ctrl_if #(.DW(16), .CW(16)) bus ();

  delay_sweep_ctrl #(.DW(16), .CW(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .sync_in (sync_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ev_q[$];
  int strobes = 0;
  int s0;

  // Model: a point lasts n_shots+1 sync edges (first discarded), edges act 3 clocks after sync_in rises.
  int m_del = 0, m_pt = 0, m_edges = 0;
  int c_step = 0, c_pts = 0, c_shots = 0;
  bit m_run = 0, m_valid = 0, m_done = 0, m_err = 0, m_sat = 0, m_cool = 0;
  bit ev, was_cool;
  int sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    ev = 0;
    if (ev_q.size() > 0 && ev_q[0] == cyc) begin
      ev = 1;
      void'(ev_q.pop_front());
    end
    m_valid = 0;
    if (reset) begin
      m_del = 0; m_pt = 0; m_edges = 0;
      m_run = 0; m_done = 0; m_err = 0; m_sat = 0; m_cool = 0;
    end else if (bus.abort) begin
      m_run = 0; m_done = 0; m_edges = 0; m_cool = 0;
    end else begin
      was_cool = m_cool;
      m_cool = 0;
      if (bus.start && !m_run && !was_cool) begin
        m_done = 0;
        if (bus.n_points == 0 || bus.n_shots == 0) begin
          m_err = 1;
        end else begin
          c_step = int'(bus.del_step); c_pts = int'(bus.n_points); c_shots = int'(bus.n_shots);
          m_del = int'(bus.del_start); m_valid = 1; m_pt = 0; m_edges = 0;
          m_sat = 0; m_err = 0; m_run = 1;
        end
      end else if (ev && m_run) begin
        m_edges++;
        if (m_edges == c_shots + 1) begin
          if (m_pt == c_pts - 1) begin
            m_run = 0; m_done = 1; m_cool = 1;
          end else begin
            m_pt++;
            m_edges = 0;
            m_valid = 1;
            sum = m_del + c_step;
            if (sum > 65535) begin
              m_del = 65535; m_sat = 1;
            end else begin
              m_del = sum;
            end
          end
        end
      end
    end
    #1;
    chk("del_out", 32'(bus.del_out), m_del);
    chk("del_valid", 32'(bus.del_valid), 32'(m_valid));
    chk("point_idx", 32'(bus.point_idx), m_pt);
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    chk("sat", 32'(bus.sat), 32'(m_sat));
    if (bus.del_valid === 1'b1) strobes++;
  end

  task automatic do_start(input int ds, input int st, input int np, input int ns);
    @(negedge clk);
    bus.del_start = 16'(ds); bus.del_step = 16'(st);
    bus.n_points = 16'(np); bus.n_shots = 16'(ns);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.del_start = 16'h1234; bus.del_step = 16'h0777;
    bus.n_points = 16'd9; bus.n_shots = 16'd9;
  endtask

  task automatic pulse(input bit with_abort, input bit with_start);
    @(negedge clk);
    sync_in = 1'b1;
    ev_q.push_back(cyc + 3);
    @(negedge clk);
    @(negedge clk);
    if (with_abort) bus.abort = 1'b1;
    if (with_start) begin
      bus.del_start = 16'd7; bus.del_step = 16'd1;
      bus.n_points = 16'd2; bus.n_shots = 16'd1;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    sync_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.del_start = '0; bus.del_step = '0; bus.n_points = '0; bus.n_shots = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset del_out", 32'(bus.del_out), 0);
    chk("reset busy", 32'(bus.busy), 0);

    // basic sweep 100/20, 3 points x 2 shots
    s0 = strobes;
    do_start(100, 20, 3, 2);
    chk("basic first del_out", 32'(bus.del_out), 100);
    chk("basic busy", 32'(bus.busy), 1);
    pulses(3);
    chk("basic p1 del_out", 32'(bus.del_out), 120);
    chk("basic p1 idx", 32'(bus.point_idx), 1);
    pulses(6);
    chk("basic done", 32'(bus.done), 1);
    chk("basic busy fall", 32'(bus.busy), 0);
    chk("basic last del_out", 32'(bus.del_out), 140);
    chk("basic last idx", 32'(bus.point_idx), 2);
    chk("basic strobes", strobes - s0, 3);
    pulses(1);
    chk("basic hold del_out", 32'(bus.del_out), 140);
    chk("basic hold done", 32'(bus.done), 1);

    // illegal config, then a legal saturating sweep clears cfg_err
    s0 = strobes;
    do_start(5, 5, 3, 0);
    chk("illegal cfg_err", 32'(bus.cfg_err), 1);
    chk("illegal busy", 32'(bus.busy), 0);
    chk("illegal done cleared", 32'(bus.done), 0);
    chk("illegal strobes", strobes - s0, 0);
    do_start(16'hFFF0, 16'h0020, 2, 1);
    chk("legal clears cfg_err", 32'(bus.cfg_err), 0);
    chk("sat first del_out", 32'(bus.del_out), 32'hFFF0);
    pulses(2);
    chk("sat del_out", 32'(bus.del_out), 32'hFFFF);
    chk("sat flag", 32'(bus.sat), 1);
    pulses(2);
    chk("sat done", 32'(bus.done), 1);
    chk("sat final del_out", 32'(bus.del_out), 32'hFFFF);

    // abort coinciding with a counted sync edge at point 1, plus a start that must be ignored
    s0 = strobes;
    do_start(100, 20, 3, 2);
    chk("abort sweep sat cleared", 32'(bus.sat), 0);
    pulses(4);
    pulse(1'b1, 1'b1);
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort done", 32'(bus.done), 0);
    chk("abort idx", 32'(bus.point_idx), 1);
    chk("abort del_out", 32'(bus.del_out), 120);
    chk("abort strobes", strobes - s0, 2);
    repeat (4) @(negedge clk);
    chk("abort start ignored", 32'(bus.busy), 0);

    // restart, then a competing start while busy must not disturb the sweep
    do_start(100, 20, 3, 2);
    chk("restart del_out", 32'(bus.del_out), 100);
    chk("restart idx", 32'(bus.point_idx), 0);
    pulses(2);
    do_start(500, 1, 1, 1);
    chk("busy start ignored", 32'(bus.del_out), 100);
    pulses(7);
    chk("busy sweep done", 32'(bus.done), 1);
    chk("busy sweep del_out", 32'(bus.del_out), 140);
    chk("busy sweep idx", 32'(bus.point_idx), 2);

    // synchronous reset while armed
    do_start(100, 20, 3, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s0 = strobes;
    chk("rst del_out", 32'(bus.del_out), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst idx", 32'(bus.point_idx), 0);
    pulses(3);
    chk("rst quiet busy", 32'(bus.busy), 0);
    chk("rst quiet del_out", 32'(bus.del_out), 0);
    chk("rst quiet strobes", strobes - s0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
